// File: rtl/e_alloc.sv
// N-entry slot allocator: registered occupancy bitmap, pre-registered next-free
// candidate (round-robin after last grant, or lowest-index-first), free port.
module e_alloc #(
  parameter  int N     = 16,
  parameter  int RR    = 1,
  localparam int ID_W  = $clog2(N),
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_req_i,
  output logic             alloc_gnt_o,
  output logic [ID_W-1:0]  alloc_id_o,
  input  logic             free_vld_i,
  input  logic [ID_W-1:0]  free_id_i,
  output logic [N-1:0]     occ_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             err_o
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0]     occ_q, occ_d, gnt_mask, free_mask;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  ptr_q, ptr_d, cand_q, cand_d, scan_id;
  logic             cand_vld_q, cand_vld_d;
  logic             full_q, empty_q, err_q;
  logic             gnt, in_range, legal_free;
  int unsigned      start, idx;

  // Grant depends only on flops, never on the same-cycle free.
  assign gnt      = alloc_req_i & cand_vld_q;
  assign in_range = int'(free_id_i) < N;

  always_comb begin
    gnt_mask   = gnt ? (ONE << cand_q) : '0;
    legal_free = free_vld_i & in_range & (|(occ_q & (ONE << free_id_i)));
    free_mask  = legal_free ? (ONE << free_id_i) : '0;
    occ_d      = (occ_q | gnt_mask) & ~free_mask;
    ptr_d      = gnt ? cand_q : ptr_q;
    cnt_d      = cnt_q;
    if (gnt && !legal_free)
      cnt_d = cnt_q + CNT_W'(1);
    else if (!gnt && legal_free)
      cnt_d = cnt_q - CNT_W'(1);
  end

  // Wrapping scan over occ_d; the first free index seen wins.
  always_comb begin
    cand_d     = '0;
    cand_vld_d = 1'b0;
    scan_id    = '0;
    idx        = 0;
    start      = 0;
    if (RR != 0)
      start = (ptr_d == ID_W'(N - 1)) ? 0 : 32'(ptr_d) + 32'd1;
    for (int unsigned k = 0; k < N; k++) begin
      idx = start + k;
      if (idx >= N)
        idx = idx - N;
      scan_id = ID_W'(idx);
      if (!cand_vld_d && !occ_d[scan_id]) begin
        cand_vld_d = 1'b1;
        cand_d     = scan_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q      <= '0;
      cnt_q      <= '0;
      ptr_q      <= ID_W'(N - 1);
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
      full_q     <= (cnt_d == CNT_W'(N));
      empty_q    <= (cnt_d == '0);
      err_q      <= err_q | (free_vld_i & ~legal_free);
    end
  end

  assign alloc_gnt_o = gnt;
  assign alloc_id_o  = cand_q;
  assign occ_o       = occ_q;
  assign cnt_o       = cnt_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign err_o       = err_q;

  a_cnt_pop: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_o == CNT_W'($countones(occ_o)));
  a_gnt_free: assert property (@(posedge clk) disable iff (!rst_n)
    alloc_gnt_o |-> ((occ_o & (ONE << alloc_id_o)) == '0));
  a_full_nogrant: assert property (@(posedge clk) disable iff (!rst_n)
    full_o |-> !alloc_gnt_o);

endmodule

// File: tb/tb_e_alloc.sv
// Bench for e_alloc: three instances (N=8 RR=1, N=8 RR=0, N=6 RR=1) share
// stimulus and are compared each cycle with a slot-list model, plus directed scenarios.
module tb_e_alloc;

  logic       clk = 1'b0;
  logic       rst_n, req, fv;
  logic [2:0] fid;

  logic       g0, g1, g2, f0, f1, f2, e0, e1, e2, r0, r1, r2;
  logic [2:0] id0, id1, id2;
  logic [7:0] occ0, occ1;
  logic [5:0] occ2;
  logic [3:0] cnt0, cnt1;
  logic [2:0] cnt2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  e_alloc #(.N(8), .RR(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .alloc_req_i(req), .alloc_gnt_o(g0), .alloc_id_o(id0),
    .free_vld_i(fv), .free_id_i(fid), .occ_o(occ0), .cnt_o(cnt0),
    .full_o(f0), .empty_o(e0), .err_o(r0));
  e_alloc #(.N(8), .RR(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .alloc_req_i(req), .alloc_gnt_o(g1), .alloc_id_o(id1),
    .free_vld_i(fv), .free_id_i(fid), .occ_o(occ1), .cnt_o(cnt1),
    .full_o(f1), .empty_o(e1), .err_o(r1));
  e_alloc #(.N(6), .RR(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .alloc_req_i(req), .alloc_gnt_o(g2), .alloc_id_o(id2),
    .free_vld_i(fv), .free_id_i(fid), .occ_o(occ2), .cnt_o(cnt2),
    .full_o(f2), .empty_o(e2), .err_o(r2));

  // Reference model: per instance a set of allocated slots plus "last granted ID".
  int        m_n  [3] = '{8, 8, 6};
  int        m_rr [3] = '{1, 0, 1};
  bit [63:0] m_occ[3];
  int        m_last[3];
  int        m_cand[3];
  bit        m_cv [3];
  bit        m_errf[3];
  bit        m_ok = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int popc(input bit [63:0] v, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic model_cmp();
    logic        og, of, oe, oer;
    logic [63:0] oid, oocc, ocnt;
    int          c;
    if (!m_ok) return;
    for (int m = 0; m < 3; m++) begin
      case (m)
        0: begin og = g0; oid = 64'(id0); oocc = 64'(occ0); ocnt = 64'(cnt0); of = f0; oe = e0; oer = r0; end
        1: begin og = g1; oid = 64'(id1); oocc = 64'(occ1); ocnt = 64'(cnt1); of = f1; oe = e1; oer = r1; end
        default: begin og = g2; oid = 64'(id2); oocc = 64'(occ2); ocnt = 64'(cnt2); of = f2; oe = e2; oer = r2; end
      endcase
      c = popc(m_occ[m], m_n[m]);
      chk($sformatf("gnt%0d", m), 64'(og), 64'(req & m_cv[m]));
      if (req && m_cv[m]) chk($sformatf("id%0d", m), oid, 64'(m_cand[m]));
      chk($sformatf("occ%0d", m), oocc, m_occ[m]);
      chk($sformatf("cnt%0d", m), ocnt, 64'(c));
      chk($sformatf("full%0d", m), 64'(of), 64'(c == m_n[m]));
      chk($sformatf("empty%0d", m), 64'(oe), 64'(c == 0));
      chk($sformatf("err%0d", m), 64'(oer), 64'(m_errf[m]));
    end
  endtask

  task automatic model_adv();
    int  n, start, j;
    bit  g, legal;
    for (int m = 0; m < 3; m++) begin
      n = m_n[m];
      if (!rst_n) begin
        m_occ[m] = '0; m_last[m] = n - 1; m_cv[m] = 1'b0; m_cand[m] = 0; m_errf[m] = 1'b0;
      end else begin
        g     = req && m_cv[m];
        legal = fv && (int'(fid) < n) && m_occ[m][fid];
        if (fv && !legal) m_errf[m] = 1'b1;
        if (g) begin
          m_occ[m][m_cand[m]] = 1'b1;
          m_last[m] = m_cand[m];
        end
        if (legal) m_occ[m][fid] = 1'b0;
        start = (m_rr[m] != 0) ? (m_last[m] + 1) % n : 0;
        m_cv[m] = 1'b0;
        m_cand[m] = 0;
        for (int k = 0; k < n; k++) begin
          j = (start + k) % n;
          if (!m_cv[m] && !m_occ[m][j]) begin
            m_cv[m] = 1'b1;
            m_cand[m] = j;
          end
        end
      end
    end
    if (!rst_n) m_ok = 1'b1;
  endtask

  // Inputs applied at the negedge; outputs sampled 1 time unit later.
  task automatic drive(input bit r, input bit v, input bit [2:0] id, input bit rn = 1'b1);
    req = r; fv = v; fid = id; rst_n = rn;
    #1;
    model_cmp();
  endtask

  task automatic tick();
    model_adv();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0); tick();
    drive(0, 0, 0, 0); tick();
  endtask

  initial begin
    do_reset();

    // Cycle after reset: reset outputs, no grant even with a request.
    drive(1, 0, 0);
    chk("rst_occ", 64'(occ0), 64'h0);
    chk("rst_empty", 64'(e0), 64'h1);
    chk("rst_full", 64'(f0), 64'h0);
    chk("rst_gnt", 64'(g0), 64'h0);
    tick();

    // Fill: IDs 0..7 in order, then full and no grant.
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0);
      chk("fill_gnt", 64'(g0), 64'h1);
      chk("fill_id", 64'(id0), 64'(i));
      tick();
    end
    drive(1, 0, 0);
    chk("full_flag", 64'(f0), 64'h1);
    chk("full_nognt", 64'(g0), 64'h0);
    tick();

    // Free 5 while full; granted on the next cycle.
    drive(1, 1, 5);
    chk("free_same_cyc", 64'(g0), 64'h0);
    tick();
    drive(1, 0, 0);
    chk("refill_gnt", 64'(g0), 64'h1);
    chk("refill_id", 64'(id0), 64'h5);
    tick();
    drive(0, 0, 0);
    chk("refill_cnt", 64'(cnt0), 64'h8);
    tick();

    // Round-robin vs lowest-first after alloc 0,1,2 and free 0.
    do_reset();
    drive(0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin drive(1, 0, 0); tick(); end
    drive(0, 1, 0); tick();
    drive(1, 0, 0);
    chk("rr_id", 64'(id0), 64'h3);
    chk("lowfirst_id", 64'(id1), 64'h0);
    tick();

    // Simultaneous grant (ID 4) and legal free (ID 1).
    drive(1, 1, 1); tick();
    drive(0, 0, 0);
    chk("simul_cnt", 64'(cnt0), 64'h3);
    chk("simul_occ", 64'(occ0), 64'h1c);
    tick();

    // Free an unallocated slot: ignored, sticky error.
    drive(0, 1, 0); tick();
    drive(0, 0, 0);
    chk("badfree_err", 64'(r0), 64'h1);
    chk("badfree_occ", 64'(occ0), 64'h1c);
    tick();
    for (int i = 0; i < 3; i++) begin drive(1, 0, 0); tick(); end
    drive(0, 0, 0);
    chk("err_sticky", 64'(r0), 64'h1);
    tick();

    // Out-of-range free on N=6 while the N=8 instance frees legally.
    do_reset();
    drive(0, 0, 0);
    chk("err_cleared", 64'(r0), 64'h0);
    tick();
    for (int i = 0; i < 8; i++) begin drive(1, 0, 0); tick(); end
    drive(0, 1, 6); tick();
    drive(0, 1, 7); tick();
    drive(0, 0, 0);
    chk("oor_err6", 64'(r2), 64'h1);
    chk("oor_occ6", 64'(occ2), 64'h3f);
    chk("oor_err8", 64'(r0), 64'h0);
    chk("oor_cnt8", 64'(cnt0), 64'h6);
    tick();

    // Reset mid-stream with 4 slots allocated.
    do_reset();
    drive(0, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin drive(1, 0, 0); tick(); end
    drive(1, 0, 0, 0); tick();
    drive(1, 0, 0);
    chk("midrst_occ", 64'(occ0), 64'h0);
    chk("midrst_cnt", 64'(cnt0), 64'h0);
    chk("midrst_gnt", 64'(g0), 64'h0);
    tick();
    drive(1, 0, 0);
    chk("midrst_first_gnt", 64'(g0), 64'h1);
    chk("midrst_first_id", 64'(id0), 64'h0);
    tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            3'($urandom_range(0, 7)), $urandom_range(0, 249) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
